// File: rtl/s84_seq_mul_fi_if.sv
// s84_seq_mul_fi_if
// Groups the request, operand, fault-control and result signals of the
// iterative fault-injection multiplier.
//
// Handshake: the master holds start high for a cycle while the slave is idle
// (busy=0). The operands and fault controls are captured on that edge. While
// busy=1, start is ignored and nothing is queued. done is a one-cycle pulse.
// y, y_gold and mismatch are valid in the done cycle and are held afterwards.
//
// Signals
//   start, a, b, op, f_loc, f_type : master -> slave
//   busy, done, y, y_gold, mismatch : slave -> master
//   dbg_state                       : slave -> master, FSM state for checkers
interface s84_seq_mul_fi_if #(
    parameter int WA    = 8,
    parameter int WB    = 4,
    parameter int LOC_W = $clog2(WA + WB)
);
    logic                 start;
    logic [WA-1:0]        a;
    logic [WB-1:0]        b;
    logic                 op;
    logic [LOC_W-1:0]     f_loc;
    logic [1:0]           f_type;
    logic                 busy;
    logic                 done;
    logic [WA+WB-1:0]     y;
    logic [WA+WB-1:0]     y_gold;
    logic                 mismatch;
    logic [1:0]           dbg_state;

    modport master (
        output start, a, b, op, f_loc, f_type,
        input  busy, done, y, y_gold, mismatch, dbg_state
    );

    modport slave (
        input  start, a, b, op, f_loc, f_type,
        output busy, done, y, y_gold, mismatch, dbg_state
    );
endinterface

// File: rtl/s84_seq_mul_fi.sv
// s84_seq_mul_fi
// Iterative shift-add multiplier (WA x WB) that runs a golden and a
// fault-injected accumulator in lockstep. One multiplier bit is consumed per
// RUN cycle, so RUN lasts WB cycles, followed by a single DONE cycle.
// op=1 selects two's complement. In that mode the top multiplier bit has
// negative weight, so its partial product is subtracted. op=0 selects
// sign-magnitude. In that mode the magnitudes are multiplied and the sign is
// attached at the end.
//
// Ports
//   clk   : rising-edge clock
//   reset : synchronous, active-high; aborts any operation in flight
//   bus   : slave side of s84_seq_mul_fi_if (request, operands, fault
//           controls, busy/done, both products, mismatch, dbg_state)
module s84_seq_mul_fi #(
    parameter int WA    = 8,
    parameter int WB    = 4,
    parameter int LOC_W = $clog2(WA + WB)
) (
    input  logic           clk,
    input  logic           reset,
    s84_seq_mul_fi_if.slave bus
);
    localparam int W      = WA + WB;
    localparam int STEP_W = (WB > 1) ? $clog2(WB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [WA-1:0]      a_q, a_d;
    logic [WB-1:0]      b_q, b_d;
    logic               op_q, op_d;
    logic [LOC_W-1:0]   f_loc_q, f_loc_d;
    logic [1:0]         f_type_q, f_type_d;
    logic [W-1:0]       acc_g_q, acc_g_d;
    logic [W-1:0]       acc_f_q, acc_f_d;
    logic [W-1:0]       y_q, y_d;
    logic [W-1:0]       y_gold_q, y_gold_d;
    logic               mismatch_q, mismatch_d;

    // Datapath for the current step.
    logic               last_step;
    logic               add_en;
    logic               sub_en;
    logic [W-1:0]       base;
    logic [W-1:0]       term;
    logic [W-1:0]       acc_g_step;
    logic [W-1:0]       acc_f_raw;
    logic [W-1:0]       acc_f_step;
    logic [W-1:0]       fault_mask;
    logic [W-1:0]       y_gold_fin;
    logic [W-1:0]       y_fin;

    // Sign-magnitude result: the sign is forced to 0 on a zero magnitude so
    // that -0 is reported as +0. The accumulator MSB is never used, which is
    // why a fault on that bit has no visible effect in this mode.
    function automatic logic [W-1:0] sm_pack(input logic sgn, input logic [W-1:0] acc);
        sm_pack = {sgn & (|acc[W-2:0]), acc[W-2:0]};
    endfunction

    always_comb begin
        last_step = (step_q == STEP_W'(WB - 1));
        // Two's complement: sign-extended a, subtract on the MSB of b.
        // Sign-magnitude: zero-extended magnitude of a, and the sign bit of b
        // contributes nothing.
        base   = op_q ? {{WB{a_q[WA-1]}}, a_q} : {{(WB + 1){1'b0}}, a_q[WA-2:0]};
        term   = base << step_q;
        add_en = b_q[step_q] && (op_q || !last_step);
        sub_en = op_q && last_step;

        acc_g_step = acc_g_q;
        acc_f_raw  = acc_f_q;
        if (add_en) begin
            acc_g_step = sub_en ? (acc_g_q - term) : (acc_g_q + term);
            acc_f_raw  = sub_en ? (acc_f_q - term) : (acc_f_q + term);
        end

        // An out-of-range f_loc matches no bit, so the mask stays empty.
        fault_mask = '0;
        for (int k = 0; k < W; k++) begin
            fault_mask[k] = (32'(f_loc_q) == k);
        end

        // Stuck-at faults are applied after every step. The flip is applied
        // only once, after the final step.
        unique case (f_type_q)
            2'b01:   acc_f_step = acc_f_raw & ~fault_mask;
            2'b10:   acc_f_step = acc_f_raw | fault_mask;
            2'b11:   acc_f_step = last_step ? (acc_f_raw ^ fault_mask) : acc_f_raw;
            default: acc_f_step = acc_f_raw;
        endcase

        y_gold_fin = op_q ? acc_g_step : sm_pack(a_q[WA-1] ^ b_q[WB-1], acc_g_step);
        y_fin      = op_q ? acc_f_step : sm_pack(a_q[WA-1] ^ b_q[WB-1], acc_f_step);
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        f_loc_d    = f_loc_q;
        f_type_d   = f_type_q;
        acc_g_d    = acc_g_q;
        acc_f_d    = acc_f_q;
        y_d        = y_q;
        y_gold_d   = y_gold_q;
        mismatch_d = mismatch_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    step_d   = '0;
                    a_d      = bus.a;
                    b_d      = bus.b;
                    op_d     = bus.op;
                    f_loc_d  = bus.f_loc;
                    f_type_d = bus.f_type;
                    acc_g_d  = '0;
                    acc_f_d  = '0;
                end
            end
            RUN: begin
                acc_g_d = acc_g_step;
                acc_f_d = acc_f_step;
                step_d  = step_q + STEP_W'(1);
                if (last_step) begin
                    // Results are registered on the edge into DONE so they
                    // are stable for the whole done pulse.
                    state_d    = DONE;
                    y_d        = y_fin;
                    y_gold_d   = y_gold_fin;
                    mismatch_d = (y_fin != y_gold_fin);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            step_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 1'b0;
            f_loc_q    <= '0;
            f_type_q   <= '0;
            acc_g_q    <= '0;
            acc_f_q    <= '0;
            y_q        <= '0;
            y_gold_q   <= '0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            f_loc_q    <= f_loc_d;
            f_type_q   <= f_type_d;
            acc_g_q    <= acc_g_d;
            acc_f_q    <= acc_f_d;
            y_q        <= y_d;
            y_gold_q   <= y_gold_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.y         = y_q;
    assign bus.y_gold    = y_gold_q;
    assign bus.mismatch  = mismatch_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_s84_seq_mul_fi.sv
// tb_s84_seq_mul_fi
// Self-checking bench for s84_seq_mul_fi: directed cases followed by random
// operands and faults, scored against a behavioural model.
module tb_s84_seq_mul_fi;
    localparam int WA = 8;
    localparam int WB = 4;
    localparam int W  = WA + WB;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [W-1:0] exp_q[$];

    s84_seq_mul_fi_if #(.WA(WA), .WB(WB)) bus ();

    s84_seq_mul_fi #(.WA(WA), .WB(WB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model. The golden product uses plain signed or magnitude
    // multiplication. The faulty product replays the per-bit weights and
    // applies the fault to the running sum after each bit.
    task automatic ref_model(input logic [7:0] a, input logic [3:0] b, input logic op,
                             input logic [3:0] fl, input logic [1:0] ft,
                             output logic [W-1:0] yf, output logic [W-1:0] yg);
        int sa, sb, mag, contrib;
        logic [W-1:0] r;
        logic sgn;
        sa  = $signed(a);
        sb  = $signed(b);
        sgn = a[7] ^ b[3];
        if (op) begin
            yg = W'(sa * sb);
        end else begin
            mag = int'(a[6:0]) * int'(b[2:0]);
            yg  = {sgn && (mag != 0), 11'(mag)};
        end
        r = '0;
        for (int i = 0; i < WB; i++) begin
            contrib = 0;
            if (b[i]) begin
                if (op) contrib = (i == WB - 1) ? -(sa * (1 << i)) : sa * (1 << i);
                else if (i < WB - 1) contrib = int'(a[6:0]) * (1 << i);
            end
            r = r + W'(contrib);
            if (fl < W) begin
                case (ft)
                    2'b01: r[fl] = 1'b0;
                    2'b10: r[fl] = 1'b1;
                    2'b11: if (i == WB - 1) r[fl] = ~r[fl];
                    default: ;
                endcase
            end
        end
        if (op) yf = r;
        else    yf = {sgn && (r[10:0] != 0), r[10:0]};
    endtask

    // Driver: one request. When noisy is set, the inputs and start are
    // scrambled during RUN. Those changes must not affect the result.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                          input logic op, input logic [3:0] fl, input logic [1:0] ft,
                          input bit noisy);
        logic [W-1:0] yf, yg, e_yg, e_yf;
        int done_cyc;
        ref_model(a, b, op, fl, ft, yf, yg);
        exp_q.push_back(yg);
        exp_q.push_back(yf);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.op = op; bus.f_loc = fl; bus.f_type = ft;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        done_cyc = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (cyc <= WB + 1) chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            if (noisy) begin
                bus.a      = 8'($urandom);
                bus.b      = 4'($urandom);
                bus.op     = 1'($urandom);
                bus.f_loc  = 4'($urandom);
                bus.f_type = 2'($urandom);
                bus.start  = 1'($urandom);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(WB + 1));
        e_yg = exp_q.pop_front();
        e_yf = exp_q.pop_front();
        if (done_cyc != 0) begin
            chk({tag, "_y_gold"}, 32'(bus.y_gold), 32'(e_yg));
            chk({tag, "_y"}, 32'(bus.y), 32'(e_yf));
            chk({tag, "_mismatch"}, 32'(bus.mismatch), 32'(e_yf != e_yg));
            @(negedge clk);
            chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
            chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
            chk({tag, "_y_hold"}, 32'(bus.y), 32'(e_yf));
        end
    endtask

    initial begin
        int dn;
        checks = 0;
        errors = 0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.op = 1'b0;
        bus.f_loc = '0; bus.f_type = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_y_gold", 32'(bus.y_gold), 32'd0);
        chk("rst_mismatch", 32'(bus.mismatch), 32'd0);

        // Directed cases, with spec constants checked directly.
        run_op("t1", 8'hFD, 4'h5, 1'b1, 4'd0, 2'b00, 1'b0);
        chk("t1_const_y", 32'(bus.y), 32'hFF1);
        run_op("t2", 8'h83, 4'h5, 1'b0, 4'd0, 2'b00, 1'b0);
        chk("t2_const_y", 32'(bus.y), 32'h80F);
        run_op("t2_neg0", 8'h80, 4'h5, 1'b0, 4'd0, 2'b00, 1'b0);
        chk("t2_neg0_const_y", 32'(bus.y), 32'h000);
        run_op("t3_sa1", 8'h03, 4'h5, 1'b1, 4'd4, 2'b10, 1'b0);
        chk("t3_const_y", 32'(bus.y), 32'h01F);
        run_op("t4_flip", 8'hFD, 4'h5, 1'b1, 4'd0, 2'b11, 1'b0);
        chk("t4_const_y", 32'(bus.y), 32'hFF0);
        run_op("t4_oob", 8'hFD, 4'h5, 1'b1, 4'hC, 2'b11, 1'b0);
        chk("t4_oob_const_mm", 32'(bus.mismatch), 32'd0);
        run_op("t5_wrap", 8'h80, 4'h8, 1'b1, 4'd0, 2'b00, 1'b1);
        chk("t5_const_y_gold", 32'(bus.y_gold), 32'h400);
        run_op("sm_msb_fault", 8'h83, 4'h5, 1'b0, 4'd11, 2'b10, 1'b0);
        run_op("sa0", 8'h7F, 4'h7, 1'b1, 4'd3, 2'b01, 1'b1);

        // Reset during step 2 of T1.
        @(negedge clk);
        bus.a = 8'hFD; bus.b = 4'h5; bus.op = 1'b1; bus.f_loc = '0; bus.f_type = '0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_y", 32'(bus.y), 32'd0);
        chk("t6_y_gold", 32'(bus.y_gold), 32'd0);
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done) dn++;
            @(negedge clk);
        end
        chk("t6_no_done", 32'(dn), 32'd0);
        run_op("t6_rerun", 8'hFD, 4'h5, 1'b1, 4'd0, 2'b00, 1'b0);
        chk("t6_rerun_const_y", 32'(bus.y), 32'hFF1);

        // Random operands and faults.
        for (int n = 0; n < 150; n++) begin
            run_op("rnd", 8'($urandom), 4'($urandom), 1'($urandom),
                   4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
